// File: rtl/rv_config.sv
// Core memory-map constants shared by the fetch path and the text memory.
// The text region is aligned to its own size, so addr[TEXT_BITS-1:2] is the word index.
package rv_config;
  localparam int          TEXT_BITS  = 10;
  localparam logic [31:0] TEXT_BEGIN = 32'h0000_1000;
  localparam logic [31:0] TEXT_END   = TEXT_BEGIN + (32'd1 << TEXT_BITS) - 32'd1;
endpackage

// File: rtl/text_memory_arbiter_pkg.sv
// Local types and defaults for the text memory arbiter.
package text_arb_pkg;
  typedef enum logic {REQ_IF = 1'b0, REQ_DBG = 1'b1} requester_t;

  localparam int DEFAULT_MAX_BURST = 4;

  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi) && (addr[1:0] == 2'b00);
  endfunction
endpackage

// File: rtl/text_memory_arbiter_if.sv
// Requester, response and text-memory signals of the arbiter, grouped in one bundle.
// slave = arbiter side; master = requesters plus the memory model.
interface text_arb_if #(
  parameter int TEXT_BITS = rv_config::TEXT_BITS
) ();
  logic                 if_req_valid;
  logic [31:0]          if_req_addr;
  logic                 if_req_ready;
  logic                 if_rsp_valid;
  logic [31:0]          if_rsp_data;
  logic                 if_rsp_err;

  logic                 dbg_req_valid;
  logic [31:0]          dbg_req_addr;
  logic                 dbg_req_we;
  logic [31:0]          dbg_req_wdata;
  logic [3:0]           dbg_req_be;
  logic                 dbg_req_ready;
  logic                 dbg_rsp_valid;
  logic [31:0]          dbg_rsp_data;
  logic                 dbg_rsp_err;

  logic [TEXT_BITS-3:0] mem_address;
  logic                 mem_we;
  logic [31:0]          mem_wdata;
  logic [3:0]           mem_be;
  logic [31:0]          mem_q;

  modport slave (
    input  if_req_valid, if_req_addr,
    input  dbg_req_valid, dbg_req_addr, dbg_req_we, dbg_req_wdata, dbg_req_be,
    input  mem_q,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output dbg_req_ready, dbg_rsp_valid, dbg_rsp_data, dbg_rsp_err,
    output mem_address, mem_we, mem_wdata, mem_be
  );

  modport master (
    output if_req_valid, if_req_addr,
    output dbg_req_valid, dbg_req_addr, dbg_req_we, dbg_req_wdata, dbg_req_be,
    output mem_q,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_data, dbg_rsp_err,
    input  mem_address, mem_we, mem_wdata, mem_be
  );
endinterface

// File: rtl/text_memory_arbiter_rr.sv
// Two-way round-robin grant with a burst cap: the last winner keeps the grant under
// contention only while its burst is live (count 1..MAX_BURST-1).
module text_arb_rr
  import text_arb_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_if_valid,
  input  logic       i_dbg_valid,
  output logic       o_grant_valid,
  output requester_t o_grant
);
  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  requester_t       r_last_grant;
  requester_t       w_last_grant_next;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_burst_cnt_next;
  logic             w_if_valid;
  logic             w_dbg_valid;

  assign w_if_valid  = i_if_valid  && reset_n;
  assign w_dbg_valid = i_dbg_valid && reset_n;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_last_grant <= REQ_DBG;
      r_burst_cnt  <= '0;
    end else begin
      r_last_grant <= w_last_grant_next;
      r_burst_cnt  <= w_burst_cnt_next;
    end
  end

  always_comb begin
    o_grant_valid     = 1'b0;
    o_grant           = REQ_IF;
    w_last_grant_next = r_last_grant;
    w_burst_cnt_next  = r_burst_cnt;

    if (w_if_valid && w_dbg_valid) begin
      o_grant_valid = 1'b1;
      // A zero count means the previous cycle was idle, so the tie goes to the other side.
      if ((r_burst_cnt != '0) && (r_burst_cnt < MAX_CNT))
        o_grant = r_last_grant;
      else
        o_grant = (r_last_grant == REQ_IF) ? REQ_DBG : REQ_IF;
    end else if (w_if_valid) begin
      o_grant_valid = 1'b1;
      o_grant       = REQ_IF;
    end else if (w_dbg_valid) begin
      o_grant_valid = 1'b1;
      o_grant       = REQ_DBG;
    end

    if (!o_grant_valid) begin
      w_burst_cnt_next = '0;
    end else if (o_grant == r_last_grant) begin
      w_burst_cnt_next = (r_burst_cnt == MAX_CNT) ? r_burst_cnt : r_burst_cnt + 1'b1;
    end else begin
      w_burst_cnt_next  = {{(CNT_W-1){1'b0}}, 1'b1};
      w_last_grant_next = o_grant;
    end
  end
endmodule

// File: rtl/text_memory_arbiter.sv
// Shares the single-port text memory between instruction fetch and the debug/loader port.
// Illegal accesses are accepted but never reach the memory; responses follow accept by one cycle.
module text_memory_arbiter
  import text_arb_pkg::*;
#(
  parameter logic [31:0] TEXT_BEGIN = rv_config::TEXT_BEGIN,
  parameter logic [31:0] TEXT_END   = rv_config::TEXT_END,
  parameter int          TEXT_BITS  = rv_config::TEXT_BITS,
  parameter int          MAX_BURST  = DEFAULT_MAX_BURST
) (
  input  logic       clock,
  input  logic       reset_n,
  text_arb_if.slave  bus
);
  logic                 w_grant_valid;
  requester_t           w_grant;
  logic [31:0]          w_sel_addr;
  logic                 w_sel_we;
  logic                 w_legal;
  logic                 w_issue;
  logic [TEXT_BITS-3:0] r_mem_address;
  logic                 r_pend_if;
  logic                 r_pend_dbg;
  logic                 r_pend_err;
  logic                 r_pend_we;
  logic [31:0]          w_rsp_data;

  text_arb_rr #(.MAX_BURST(MAX_BURST)) u_rr (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_if_valid    (bus.if_req_valid),
    .i_dbg_valid   (bus.dbg_req_valid),
    .o_grant_valid (w_grant_valid),
    .o_grant       (w_grant)
  );

  assign w_sel_addr = (w_grant == REQ_DBG) ? bus.dbg_req_addr : bus.if_req_addr;
  assign w_sel_we   = (w_grant == REQ_DBG) && bus.dbg_req_we;
  assign w_legal    = addr_legal(w_sel_addr, TEXT_BEGIN, TEXT_END);
  assign w_issue    = w_grant_valid && w_legal;

  assign bus.if_req_ready  = w_grant_valid && (w_grant == REQ_IF);
  assign bus.dbg_req_ready = w_grant_valid && (w_grant == REQ_DBG);

  assign bus.mem_we      = w_issue && w_sel_we;
  assign bus.mem_wdata   = bus.mem_we ? bus.dbg_req_wdata : 32'h0;
  assign bus.mem_be      = bus.mem_we ? bus.dbg_req_be : 4'h0;
  assign bus.mem_address = w_issue ? w_sel_addr[TEXT_BITS-1:2] : r_mem_address;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_mem_address <= '0;
      r_pend_if     <= 1'b0;
      r_pend_dbg    <= 1'b0;
      r_pend_err    <= 1'b0;
      r_pend_we     <= 1'b0;
    end else begin
      if (w_issue)
        r_mem_address <= w_sel_addr[TEXT_BITS-1:2];
      r_pend_if  <= w_grant_valid && (w_grant == REQ_IF);
      r_pend_dbg <= w_grant_valid && (w_grant == REQ_DBG);
      r_pend_err <= w_grant_valid && !w_legal;
      r_pend_we  <= w_grant_valid && w_sel_we;
    end
  end

  // mem_q is only meaningful for a legal read issued last cycle.
  assign w_rsp_data = (r_pend_err || r_pend_we) ? 32'h0 : bus.mem_q;

  assign bus.if_rsp_valid  = r_pend_if;
  assign bus.if_rsp_data   = r_pend_if ? w_rsp_data : 32'h0;
  assign bus.if_rsp_err    = r_pend_if && r_pend_err;
  assign bus.dbg_rsp_valid = r_pend_dbg;
  assign bus.dbg_rsp_data  = r_pend_dbg ? w_rsp_data : 32'h0;
  assign bus.dbg_rsp_err   = r_pend_dbg && r_pend_err;
endmodule

// File: tb/tb_text_memory_arbiter.sv
// Randomized bench for text_memory_arbiter with a behavioural grant/memory reference model.
module tb_text_memory_arbiter;
  localparam int          TB_BITS  = rv_config::TEXT_BITS;
  localparam logic [31:0] TB_BEGIN = rv_config::TEXT_BEGIN;
  localparam logic [31:0] TB_END   = rv_config::TEXT_END;
  localparam int          WORDS    = 1 << (TB_BITS - 2);
  localparam int          MAXB     = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  text_arb_if #(.TEXT_BITS(TB_BITS)) bus ();

  text_memory_arbiter #(
    .TEXT_BEGIN(TB_BEGIN), .TEXT_END(TB_END), .TEXT_BITS(TB_BITS), .MAX_BURST(MAXB)
  ) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Text memory environment: registered read, byte-enabled write.
  logic [31:0] mem_env [0:WORDS-1];
  always @(posedge clk) begin
    if (bus.mem_we)
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) mem_env[bus.mem_address][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    bus.mem_q <= mem_env[bus.mem_address];
  end

  // Reference model state
  logic [31:0] model_mem [0:WORDS-1];
  int          last_side;
  int          run_len;
  bit          e_if_v, e_dbg_v, e_if_err, e_dbg_err;
  logic [31:0] e_if_d, e_dbg_d;
  bit          addr_known;
  int          e_addr;

  int checks = 0;
  int failures = 0;
  int rsp_seen = 0;
  bit s_if_rdy, s_dbg_rdy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i < 3) return 32'h11 * (i + 1);
    return 32'hA500_0000 ^ (i * 32'h0001_0203);
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0:       return TB_END + 32'd1;
      1:       return TB_BEGIN + ($urandom_range(0, WORDS - 1) << 2) + $urandom_range(1, 3);
      2:       return TB_BEGIN - 32'd4;
      3:       return TB_END - 32'd3;
      default: return TB_BEGIN + ($urandom_range(0, 15) << 2);
    endcase
  endfunction

  task automatic model_reset();
    last_side  = 1;
    run_len    = 0;
    e_if_v     = 0; e_dbg_v = 0; e_if_err = 0; e_dbg_err = 0;
    e_if_d     = 0; e_dbg_d = 0;
    addr_known = 0;
  endtask

  // One clock cycle: drive, check at negedge, update the model at the edge.
  task automatic step(input bit rn, input bit late_rst,
                      input bit iv, input logic [31:0] ia,
                      input bit dv, input logic [31:0] da, input bit dwe,
                      input logic [31:0] dwd, input logic [3:0] dbe);
    int          g;
    int          idx;
    bit          legal, we;
    logic [31:0] a, rd;
    reset_n           = rn;
    bus.if_req_valid  = iv;
    bus.if_req_addr   = ia;
    bus.dbg_req_valid = dv;
    bus.dbg_req_addr  = da;
    bus.dbg_req_we    = dwe;
    bus.dbg_req_wdata = dwd;
    bus.dbg_req_be    = dbe;
    @(negedge clk);
    check_eq("if_rsp_valid",  bus.if_rsp_valid,  e_if_v);
    check_eq("if_rsp_data",   bus.if_rsp_data,   e_if_d);
    check_eq("if_rsp_err",    bus.if_rsp_err,    e_if_err);
    check_eq("dbg_rsp_valid", bus.dbg_rsp_valid, e_dbg_v);
    check_eq("dbg_rsp_data",  bus.dbg_rsp_data,  e_dbg_d);
    check_eq("dbg_rsp_err",   bus.dbg_rsp_err,   e_dbg_err);
    rsp_seen += int'(bus.if_rsp_valid) + int'(bus.dbg_rsp_valid);

    g = -1;
    if (rn) begin
      if (iv && dv) g = (run_len > 0 && run_len < MAXB) ? last_side : 1 - last_side;
      else if (iv)  g = 0;
      else if (dv)  g = 1;
    end
    a     = (g == 1) ? da : ia;
    legal = (g >= 0) && (a >= TB_BEGIN) && (a <= TB_END) && (a % 4 == 0);
    we    = legal && (g == 1) && dwe;
    idx   = int'((a - TB_BEGIN) >> 2);
    s_if_rdy  = bus.if_req_ready;
    s_dbg_rdy = bus.dbg_req_ready;
    check_eq("if_req_ready",  bus.if_req_ready,  32'(g == 0));
    check_eq("dbg_req_ready", bus.dbg_req_ready, 32'(g == 1));
    check_eq("mem_we",        bus.mem_we,        32'(we));
    if (legal) check_eq("mem_address", bus.mem_address, idx);
    else if (addr_known) check_eq("mem_address_hold", bus.mem_address, e_addr);
    if (we) begin
      check_eq("mem_wdata", bus.mem_wdata, dwd);
      check_eq("mem_be",    bus.mem_be,    dbe);
    end
    if (g >= 0)
      $display("txn t=%0t side=%s addr=%h we=%0d legal=%0d", $time,
               (g == 0) ? "IF " : "DBG", a, (g == 1) && dwe, legal);
    if (late_rst) reset_n = 1'b0;

    @(posedge clk);
    if (!rn || late_rst) begin
      model_reset();
    end else begin
      rd        = (legal && !((g == 1) && dwe)) ? model_mem[idx] : 32'h0;
      e_if_v    = (g == 0);
      e_dbg_v   = (g == 1);
      e_if_err  = (g == 0) && !legal;
      e_dbg_err = (g == 1) && !legal;
      e_if_d    = (g == 0) ? rd : 32'h0;
      e_dbg_d   = (g == 1) ? rd : 32'h0;
      if (we)
        for (int b = 0; b < 4; b++)
          if (dbe[b]) model_mem[idx][8*b +: 8] = dwd[8*b +: 8];
      if (legal) begin
        addr_known = 1;
        e_addr     = idx;
      end
      if (g < 0) run_len = 0;
      else if (g == last_side) run_len++;
      else begin
        run_len   = 1;
        last_side = g;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0);
  endtask

  task automatic if_rd(input logic [31:0] a);
    step(1, 0, 1, a, 0, 32'h0, 0, 32'h0, 4'h0);
  endtask

  initial begin
    int base, if_wait, dbg_wait;
    for (int i = 0; i < WORDS; i++) begin
      mem_env[i]   = init_word(i);
      model_mem[i] = init_word(i);
    end
    reset_n = 1'b0;
    bus.if_req_valid = 0; bus.if_req_addr = 0;
    bus.dbg_req_valid = 0; bus.dbg_req_addr = 0; bus.dbg_req_we = 0;
    bus.dbg_req_wdata = 0; bus.dbg_req_be = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    repeat (5) idle();

    if_rd(TB_BEGIN);
    if_rd(TB_BEGIN + 32'd4);
    if_rd(TB_BEGIN + 32'd8);
    idle();

    base = rsp_seen; if_wait = 0; dbg_wait = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 1, TB_BEGIN + ($urandom_range(0, 15) << 2),
           1, TB_BEGIN + ($urandom_range(0, 15) << 2), 0, 32'h0, 4'h0);
      if_wait  = s_if_rdy  ? 0 : if_wait + 1;
      dbg_wait = s_dbg_rdy ? 0 : dbg_wait + 1;
      check_eq("if_wait_bound",  32'(if_wait  <= MAXB), 32'd1);
      check_eq("dbg_wait_bound", 32'(dbg_wait <= MAXB), 32'd1);
    end
    idle();
    check_eq("contention_rsp_count", rsp_seen - base, 32'd12);

    step(1, 0, 0, 32'h0, 1, TB_BEGIN + 32'h10, 1, 32'hDEAD_BEEF, 4'hF);
    if_rd(TB_BEGIN + 32'h10);
    idle();

    if_rd(TB_END + 32'd1);
    if_rd(TB_BEGIN + 32'd2);
    step(1, 0, 0, 32'h0, 1, TB_END + 32'd1, 1, 32'h1234_5678, 4'hF);
    step(1, 0, 0, 32'h0, 1, TB_BEGIN + 32'd6, 1, 32'h8765_4321, 4'hF);
    if_rd(TB_BEGIN + 32'd4);
    if_rd(TB_END - 32'd3);
    idle();

    for (int i = 0; i < 300; i++) begin
      step(1, 0, 1'($urandom_range(0, 3) != 0), rand_addr(),
           1'($urandom_range(0, 2) != 0), rand_addr(), 1'($urandom_range(0, 1)),
           $urandom, 4'($urandom_range(0, 15)));
    end
    idle();

    step(1, 1, 0, 32'h0, 1, TB_BEGIN + 32'h20, 0, 32'h0, 4'h0);
    idle();
    step(1, 0, 1, TB_BEGIN + 32'h24, 1, TB_BEGIN + 32'h28, 0, 32'h0, 4'h0);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
